// File: rtl/pifo_calendar_rank_ctrl.sv
// ============================================================================
// Module   : pifo_calendar_rank_ctrl
// Purpose  : STFQ rank computation and insert/pop strobe control for the
//            calendar PIFO atom chain. Optional PIFO_RANK_CTRL_STATS_EN adds
//            enqueue/dequeue/saturation event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pifo_calendar_rank_ctrl #(
  parameter int ELEMENT_WIDTH       = 32,
  parameter int ELEMENT_RANK_WIDTH  = 19,
  parameter int RANK_START_POS      = 12,
  parameter int RANK_END_POS        = 30,
  parameter int PIFO_INFO_VALID_POS = 31,
  parameter int FLOW_ID_WIDTH       = 4,
  parameter int LEN_WIDTH           = 16,
  parameter int PIFO_DEPTH          = 16,
  parameter int COUNT_WIDTH         = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_enq_valid,
  output logic                          out_enq_ready,
  input  logic [FLOW_ID_WIDTH-1:0]      in_enq_flow_id,
  input  logic [LEN_WIDTH-1:0]          in_enq_len,
  input  logic [RANK_START_POS-1:0]     in_enq_payload,
  input  logic                          in_deq_valid,
  output logic                          out_deq_ready,
  output logic                          out_deq_valid,
  output logic [ELEMENT_WIDTH-1:0]      out_deq_data,
  output logic [ELEMENT_WIDTH-1:0]      out_pifo_input,
  output logic                          out_ctl_insert,
  output logic                          out_ctl_pop,
  input  logic [ELEMENT_WIDTH-1:0]      in_pifo_head,
  output logic [COUNT_WIDTH-1:0]        out_count,
  output logic [ELEMENT_RANK_WIDTH-1:0] out_vtime
`ifdef PIFO_RANK_CTRL_STATS_EN
  ,
  output logic [31:0]                   out_stat_enq,
  output logic [31:0]                   out_stat_deq,
  output logic [15:0]                   out_stat_sat
`endif
);

  localparam int                            c_NUM_FLOWS = 2 ** FLOW_ID_WIDTH;
  localparam logic [COUNT_WIDTH-1:0]        c_DEPTH     = COUNT_WIDTH'(PIFO_DEPTH);
  localparam logic [ELEMENT_RANK_WIDTH-1:0] c_RANK_MAX  = '1;

  logic [COUNT_WIDTH-1:0]        r_count;
  logic [ELEMENT_RANK_WIDTH-1:0] r_vtime;
  logic [ELEMENT_RANK_WIDTH-1:0] r_last_finish [c_NUM_FLOWS];
  logic [ELEMENT_WIDTH-1:0]      r_pifo_input;
  logic [ELEMENT_WIDTH-1:0]      r_deq_data;
  logic                          r_ctl_insert;
  logic                          r_ctl_pop;
  logic                          r_deq_valid;

  logic                          w_enq_fire;
  logic                          w_deq_fire;
  logic [ELEMENT_RANK_WIDTH-1:0] w_last_finish;
  logic [ELEMENT_RANK_WIDTH-1:0] w_start;
  logic [ELEMENT_RANK_WIDTH:0]   w_sum;
  logic                          w_sat;
  logic [ELEMENT_RANK_WIDTH-1:0] w_finish;
  logic [ELEMENT_WIDTH-1:0]      w_new_elem;
  logic [ELEMENT_RANK_WIDTH-1:0] w_head_rank;
  logic [ELEMENT_RANK_WIDTH-1:0] w_vtime_nxt;

  // Readies come from registered occupancy only, so no valid->ready path exists.
  assign out_enq_ready = (r_count < c_DEPTH);
  assign out_deq_ready = (r_count != '0);
  assign w_enq_fire    = in_enq_valid & out_enq_ready;
  assign w_deq_fire    = in_deq_valid & out_deq_ready;

  assign w_last_finish = r_last_finish[in_enq_flow_id];
  assign w_start       = (r_vtime > w_last_finish) ? r_vtime : w_last_finish;
  assign w_sum         = {1'b0, w_start} + (ELEMENT_RANK_WIDTH+1)'(in_enq_len);
  assign w_sat         = w_sum[ELEMENT_RANK_WIDTH];
  assign w_finish      = w_sat ? c_RANK_MAX : w_sum[ELEMENT_RANK_WIDTH-1:0];

  always_comb begin
    w_new_elem                                = '0;
    w_new_elem[PIFO_INFO_VALID_POS]           = 1'b1;
    w_new_elem[RANK_END_POS:RANK_START_POS]   = w_start;
    w_new_elem[RANK_START_POS-1:0]            = in_enq_payload;
  end

  assign w_head_rank = in_pifo_head[RANK_END_POS:RANK_START_POS];
  assign w_vtime_nxt = (w_head_rank > r_vtime) ? w_head_rank : r_vtime;

  // The table is written on the accept edge, so a following enqueue to the
  // same flow already reads the new finish time without any bypass.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < c_NUM_FLOWS; i++) begin
        r_last_finish[i] <= '0;
      end
    end else if (w_enq_fire) begin
      r_last_finish[in_enq_flow_id] <= w_finish;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count      <= '0;
      r_vtime      <= '0;
      r_pifo_input <= '0;
      r_deq_data   <= '0;
      r_ctl_insert <= 1'b0;
      r_ctl_pop    <= 1'b0;
      r_deq_valid  <= 1'b0;
    end else begin
      r_ctl_insert <= w_enq_fire;
      r_ctl_pop    <= w_deq_fire;
      r_deq_valid  <= r_ctl_pop;
      if (w_enq_fire) begin
        r_pifo_input <= w_new_elem;
      end
      // While the pop strobe is high the chain head is the departing element.
      if (r_ctl_pop) begin
        r_deq_data <= in_pifo_head;
        r_vtime    <= w_vtime_nxt;
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_deq_valid  = r_deq_valid;
  assign out_deq_data   = r_deq_data;
  assign out_pifo_input = r_pifo_input;
  assign out_ctl_insert = r_ctl_insert;
  assign out_ctl_pop    = r_ctl_pop;
  assign out_count      = r_count;
  assign out_vtime      = r_vtime;

`ifdef PIFO_RANK_CTRL_STATS_EN
  logic [31:0] r_stat_enq;
  logic [31:0] r_stat_deq;
  logic [15:0] r_stat_sat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stat_enq <= '0;
      r_stat_deq <= '0;
      r_stat_sat <= '0;
    end else begin
      if (w_enq_fire) begin
        r_stat_enq <= r_stat_enq + 32'd1;
      end
      if (w_deq_fire) begin
        r_stat_deq <= r_stat_deq + 32'd1;
      end
      if (w_enq_fire && w_sat) begin
        r_stat_sat <= r_stat_sat + 16'd1;
      end
    end
  end

  assign out_stat_enq = r_stat_enq;
  assign out_stat_deq = r_stat_deq;
  assign out_stat_sat = r_stat_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pifo_calendar_rank_ctrl.sv
// ============================================================================
// Module   : tb_pifo_calendar_rank_ctrl
// Purpose  : Scoreboard bench for pifo_calendar_rank_ctrl with a sorted-queue
//            atom chain and an STFQ reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pifo_calendar_rank_ctrl;

  localparam int c_RMAX = 19'h7FFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_enq_valid = 1'b0;
  logic        out_enq_ready;
  logic [3:0]  in_enq_flow_id = '0;
  logic [15:0] in_enq_len = '0;
  logic [11:0] in_enq_payload = '0;
  logic        in_deq_valid = 1'b0;
  logic        out_deq_ready;
  logic        out_deq_valid;
  logic [31:0] out_deq_data;
  logic [31:0] out_pifo_input;
  logic        out_ctl_insert;
  logic        out_ctl_pop;
  logic [31:0] in_pifo_head = '0;
  logic [4:0]  out_count;
  logic [18:0] out_vtime;
`ifdef PIFO_RANK_CTRL_STATS_EN
  logic [31:0] out_stat_enq;
  logic [31:0] out_stat_deq;
  logic [15:0] out_stat_sat;
`endif

  pifo_calendar_rank_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_enq_valid   (in_enq_valid),
    .out_enq_ready  (out_enq_ready),
    .in_enq_flow_id (in_enq_flow_id),
    .in_enq_len     (in_enq_len),
    .in_enq_payload (in_enq_payload),
    .in_deq_valid   (in_deq_valid),
    .out_deq_ready  (out_deq_ready),
    .out_deq_valid  (out_deq_valid),
    .out_deq_data   (out_deq_data),
    .out_pifo_input (out_pifo_input),
    .out_ctl_insert (out_ctl_insert),
    .out_ctl_pop    (out_ctl_pop),
    .in_pifo_head   (in_pifo_head),
    .out_count      (out_count),
    .out_vtime      (out_vtime)
`ifdef PIFO_RANK_CTRL_STATS_EN
    ,
    .out_stat_enq   (out_stat_enq),
    .out_stat_deq   (out_stat_deq),
    .out_stat_sat   (out_stat_sat)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_count;
  int          m_vtime;
  int          m_lf [16];
  logic [31:0] m_pifo [$];
  int          m_enq, m_deq, m_sat;
  bit          vd1, vd2;
  int          vr1, vr2;

  // Scoreboard queues
  logic [31:0] exp_ins [$];
  logic [31:0] exp_deq [$];

  // Atom chain environment
  logic [31:0] chain [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Lowest rank leaves first; equal ranks keep arrival order.
  function automatic int find_pos(input logic [31:0] q[$], input logic [18:0] r);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][30:12] > r) return i;
    end
    return q.size();
  endfunction

  initial begin
    logic s_pop, s_ins, s_rst;
    logic [31:0] s_din;
    forever begin
      @(negedge clk);
      s_pop = out_ctl_pop;
      s_ins = out_ctl_insert;
      s_din = out_pifo_input;
      s_rst = !rstn;
      @(posedge clk);
      #1;
      if (s_rst) begin
        chain.delete();
      end else begin
        if (s_pop && chain.size() > 0) void'(chain.pop_front());
        if (s_ins) chain.insert(find_pos(chain, s_din[30:12]), s_din);
      end
      in_pifo_head = (chain.size() > 0) ? chain[0] : 32'h0;
    end
  end

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (out_ctl_insert) begin
          if (exp_ins.size() == 0) chk("insert_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_ins.pop_front();
            chk("pifo_input", out_pifo_input, e);
          end
        end
        if (out_deq_valid) begin
          if (exp_deq.size() == 0) chk("deq_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_deq.pop_front();
            chk("deq_data", out_deq_data, e);
          end
        end
      end
    end
  end

  task automatic step(input bit ev, input logic [3:0] fl, input logic [15:0] ln,
                      input logic [11:0] pl, input bit dv);
    bit ef, df;
    int st, fin;
    logic [31:0] e;
    if (vd2 && vr2 > m_vtime) m_vtime = vr2;
    chk("count", 32'(out_count), 32'(m_count));
    chk("enq_ready", 32'(out_enq_ready), 32'(m_count < 16));
    chk("deq_ready", 32'(out_deq_ready), 32'(m_count != 0));
    chk("vtime", 32'(out_vtime), 32'(m_vtime));
`ifdef PIFO_RANK_CTRL_STATS_EN
    chk("stat_enq", out_stat_enq, 32'(m_enq));
    chk("stat_deq", out_stat_deq, 32'(m_deq));
    chk("stat_sat", 32'(out_stat_sat), 32'(m_sat));
`endif
    in_enq_valid   = ev;
    in_enq_flow_id = fl;
    in_enq_len     = ln;
    in_enq_payload = pl;
    in_deq_valid   = dv;
    ef = ev && (m_count < 16);
    df = dv && (m_count != 0);
    vd2 = vd1;
    vr2 = vr1;
    vd1 = 1'b0;
    if (df) begin
      e = m_pifo.pop_front();
      exp_deq.push_back(e);
      vd1 = 1'b1;
      vr1 = int'(e[30:12]);
      m_deq++;
    end
    if (ef) begin
      st  = (m_vtime > m_lf[fl]) ? m_vtime : m_lf[fl];
      fin = st + int'(ln);
      if (fin > c_RMAX) begin
        fin = c_RMAX;
        m_sat++;
      end
      m_lf[fl] = fin;
      e = {1'b1, 19'(st), pl};
      exp_ins.push_back(e);
      m_pifo.insert(find_pos(m_pifo, e[30:12]), e);
      m_enq++;
    end
    if (ef && !df) m_count++;
    else if (df && !ef) m_count--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 12'd0, 1'b0);
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    in_enq_valid = 1'b0;
    in_deq_valid = 1'b0;
    @(posedge clk);
    #1;
    m_count = 0;
    m_vtime = 0;
    for (int i = 0; i < 16; i++) m_lf[i] = 0;
    m_pifo.delete();
    exp_ins.delete();
    exp_deq.delete();
    vd1 = 1'b0;
    vd2 = 1'b0;
    vr1 = 0;
    vr2 = 0;
    m_enq = 0;
    m_deq = 0;
    m_sat = 0;
    chk("rst_insert", 32'(out_ctl_insert), 32'd0);
    chk("rst_pop", 32'(out_ctl_pop), 32'd0);
    chk("rst_deq_valid", 32'(out_deq_valid), 32'd0);
    chk("rst_pifo_input", out_pifo_input, 32'd0);
    chk("rst_deq_data", out_deq_data, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_vtime", 32'(out_vtime), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    int pe, pd;
    do_reset();

    // Single enqueue: rank 0, element 0x800000AB
    step(1'b1, 4'd3, 16'd100, 12'h0AB, 1'b0);
    idle(3);

    // Back-to-back on one flow: ranks 0 then 100
    do_reset();
    step(1'b1, 4'd3, 16'd100, 12'h001, 1'b0);
    step(1'b1, 4'd3, 16'd100, 12'h002, 1'b0);
    step(1'b1, 4'd3, 16'd1,   12'h003, 1'b0);
    idle(3);

    // Two flows then a pop of the rank-0 head
    do_reset();
    step(1'b1, 4'd1, 16'd50, 12'h011, 1'b0);
    step(1'b1, 4'd2, 16'd10, 12'h022, 1'b0);
    step(1'b0, 4'd0, 16'd0,  12'h000, 1'b1);
    idle(4);

    // Full chain: enqueue refused, simultaneous pop accepted
    do_reset();
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'($urandom_range(15, 0)), 16'($urandom_range(200, 0)), 12'(i), 1'b0);
    step(1'b1, 4'd9, 16'd5, 12'hFFF, 1'b1);
    step(1'b1, 4'd9, 16'd5, 12'hFFE, 1'b1);
    idle(3);

    // Empty chain: pop refused, simultaneous enqueue accepted
    do_reset();
    step(1'b1, 4'd7, 16'd20, 12'h077, 1'b1);
    step(1'b0, 4'd0, 16'd0,  12'h000, 1'b1);
    idle(3);

    // Randomised traffic with a reset landing mid-stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pe = ((i % 200) < 100) ? 85 : 40;
      pd = ((i % 200) < 100) ? 30 : 75;
      if (i == 300) do_reset();
      step(1'($urandom_range(99, 0) < pe), 4'($urandom_range(15, 0)),
           16'($urandom_range(300, 0)), 12'($urandom_range(4095, 0)),
           1'($urandom_range(99, 0) < pd));
    end
    idle(4);

    // Saturation via last_finish, then via vtime
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 4'd0, 16'd65504, 12'(i), 1'b0);
    step(1'b1, 4'd0, 16'h0200, 12'h0F0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 4'd0, 16'd0, 12'd0, 1'b1);
    idle(3);
    step(1'b1, 4'd5, 16'h0200, 12'h055, 1'b0);
    idle(5);

    chk("ins_outstanding", 32'(exp_ins.size()), 32'd0);
    chk("deq_outstanding", 32'(exp_deq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
